// File: rtl/prog_seq_if.sv
// prog_seq_if: handshake and status bundle between the batch sequencer and
// whatever launches batches and hosts the single-cycle core.
//   slave  : the sequencer (samples start/core_done, drives everything else)
//   master : the host side (drives start/core_done, observes status)
// NUM_PROGS must match the NUM_PROGS of the prog_sequencer it is bound to.
interface prog_seq_if #(
    parameter int NUM_PROGS = 3
);
    logic                 start;
    logic                 core_done;
    logic                 core_reset;
    logic [1:0]           pmux;
    logic                 busy;
    logic                 all_done;
    logic                 timeout_err;
    logic [NUM_PROGS-1:0] prog_fail;
    logic [15:0]          cycle_count;

    modport slave (
        input  start,
        input  core_done,
        output core_reset,
        output pmux,
        output busy,
        output all_done,
        output timeout_err,
        output prog_fail,
        output cycle_count
    );

    modport master (
        output start,
        output core_done,
        input  core_reset,
        input  pmux,
        input  busy,
        input  all_done,
        input  timeout_err,
        input  prog_fail,
        input  cycle_count
    );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs programs 0..NUM_PROGS-1 on the single-cycle core back
// to back. For each program it holds the core in reset, releases it, waits for
// its done flag, lets final memory writes drain, then steps to the next
// program. A per-program RUN cycle count is reported on cycle_count.
//
// Optional feature macro: PROG_SEQ_TIMEOUT_EN
//   defined   : each program gets a TIMEOUT-cycle RUN budget; overruns set
//               prog_fail[p] and the sticky timeout_err.
//   undefined : RUN waits for core_done forever, timeout_err/prog_fail are 0,
//               and the shared counter saturates instead of wrapping.
//
// Reset is synchronous and active-low. Every output is a flop.
module prog_sequencer #(
    parameter int NUM_PROGS    = 3,
    parameter int RESET_CYCLES = 2,
    parameter int DONE_GUARD   = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int TIMEOUT      = 500
) (
    input logic       clk,
    input logic       reset,
    prog_seq_if.slave bus
);

    // Elaboration-time range checks on the configuration.
    if (NUM_PROGS < 1 || NUM_PROGS > 4) begin : g_bad_num_progs
        $error("prog_sequencer: NUM_PROGS must be 1..4");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("prog_sequencer: TIMEOUT must be 2..65535");
    end
    if (RESET_CYCLES < 1 || DRAIN_CYCLES < 1) begin : g_bad_cycles
        $error("prog_sequencer: RESET_CYCLES and DRAIN_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_CORE,
        ST_RUN,
        ST_DRAIN,
        ST_NEXT,
        ST_FINISH
    } state_e;

    localparam logic [15:0] RESET_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
    localparam logic [15:0] GUARD      = 16'(DONE_GUARD);
    localparam logic [1:0]  LAST_PROG  = 2'(NUM_PROGS - 1);
`ifdef PROG_SEQ_TIMEOUT_EN
    localparam logic [15:0] RUN_LAST   = 16'(TIMEOUT - 1);
    localparam logic [15:0] RUN_BUDGET = 16'(TIMEOUT);
`endif

    state_e      state;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        core_reset_r;
    logic [1:0]  pmux_r;
    logic        busy_r;
    logic        all_done_r;
    logic [15:0] cycle_count_r;
`ifdef PROG_SEQ_TIMEOUT_EN
    logic                 timeout_err_r;
    logic [NUM_PROGS-1:0] prog_fail_r;
`endif

    // Next value of the shared counter: wraps with the timeout budget in
    // place (it can never reach the top), saturates when RUN is unbounded.
    always_comb begin
`ifdef PROG_SEQ_TIMEOUT_EN
        cnt_inc = cnt + 16'd1;
`else
        cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
`endif
    end

    // Batch state machine; every output is registered here.
    // NOTE: all state and outputs use non-blocking assignments so every flop
    // in this block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            core_reset_r  <= 1'b1;
            pmux_r        <= '0;
            busy_r        <= 1'b0;
            all_done_r    <= 1'b0;
            cycle_count_r <= '0;
`ifdef PROG_SEQ_TIMEOUT_EN
            timeout_err_r <= 1'b0;
            prog_fail_r   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    core_reset_r <= 1'b1;
                    if (bus.start) begin
                        state      <= ST_RESET_CORE;
                        pmux_r     <= '0;
                        busy_r     <= 1'b1;
                        all_done_r <= 1'b0;
                        cnt        <= '0;
`ifdef PROG_SEQ_TIMEOUT_EN
                        timeout_err_r <= 1'b0;
                        prog_fail_r   <= '0;
`endif
                    end
                end

                ST_RESET_CORE: begin
                    // Core reset is released on the same edge RUN is entered.
                    if (cnt == RESET_LAST) begin
                        state        <= ST_RUN;
                        cnt          <= '0;
                        core_reset_r <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_RUN: begin
                    // A done left over from the previous program is masked by
                    // the guard window; a real done beats a same-cycle timeout.
                    if (bus.core_done && (cnt >= GUARD)) begin
                        cycle_count_r <= cnt_inc;
                        cnt           <= '0;
                        state         <= ST_DRAIN;
                    end
`ifdef PROG_SEQ_TIMEOUT_EN
                    else if (cnt == RUN_LAST) begin
                        for (int p = 0; p < NUM_PROGS; p++) begin
                            if (pmux_r == 2'(p)) begin
                                prog_fail_r[p] <= 1'b1;
                            end
                        end
                        timeout_err_r <= 1'b1;
                        cycle_count_r <= RUN_BUDGET;
                        cnt           <= '0;
                        core_reset_r  <= 1'b1;
                        state         <= ST_NEXT;
                    end
`endif
                    else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_DRAIN: begin
                    // Core keeps running so its last data-memory writes land.
                    if (cnt == DRAIN_LAST) begin
                        cnt          <= '0;
                        core_reset_r <= 1'b1;
                        state        <= ST_NEXT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_NEXT: begin
                    if (pmux_r == LAST_PROG) begin
                        busy_r     <= 1'b0;
                        all_done_r <= 1'b1;
                        state      <= ST_FINISH;
                    end else begin
                        pmux_r <= pmux_r + 2'd1;
                        cnt    <= '0;
                        state  <= ST_RESET_CORE;
                    end
                end

                ST_FINISH: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.core_reset  = core_reset_r;
    assign bus.pmux        = pmux_r;
    assign bus.busy        = busy_r;
    assign bus.all_done    = all_done_r;
    assign bus.cycle_count = cycle_count_r;
`ifdef PROG_SEQ_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_r;
    assign bus.prog_fail   = prog_fail_r;
`else
    assign bus.timeout_err = 1'b0;
    assign bus.prog_fail   = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed bench for prog_sequencer with a behavioural
// core model and a scoreboard. Stimulus pushes the expected per-program and
// end-of-batch records; a monitor pops and compares them when the DUT shows
// a program end (core_reset rising while busy) or a batch end (busy falling
// with all_done set). Timeout scenarios run only when PROG_SEQ_TIMEOUT_EN is
// defined.
module tb_prog_sequencer;

    localparam int NP      = 3;
    localparam int TIMEOUT = 500;

    logic clk = 1'b0;
    logic reset = 1'b0;

    prog_seq_if #(.NUM_PROGS(NP)) bus ();

    prog_sequencer #(
        .NUM_PROGS    (NP),
        .RESET_CYCLES (2),
        .DONE_GUARD   (2),
        .DRAIN_CYCLES (4),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef enum int { EV_PROG, EV_FINISH } ev_e;
    typedef struct {
        ev_e         kind;
        logic [1:0]  pmux;
        logic [15:0] cyc;
        logic [NP-1:0] fail;
        logic        terr;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- core model ----------------
    // c = RUN-relative cycle index of the current program (-1 while in reset).
    // mode 0: done from cycle tgt-1 onward; 1: never done;
    // mode 2: stale done in cycles <=1, low until cycle 7, then high.
    int mode [NP];
    int tgt  [NP];
    int c = -1;

    always @(negedge clk) begin
        int p;
        if (bus.core_reset) c = -1;
        else                c = c + 1;
        p = int'(bus.pmux);
        if (p >= NP) p = 0;
        case (mode[p])
            0:       bus.core_done = (c >= tgt[p] - 1);
            1:       bus.core_done = 1'b0;
            default: bus.core_done = (c <= 1) || (c >= 7);
        endcase
    end

    // ---------------- monitor ----------------
    logic prev_cr   = 1'b1;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.core_reset && !prev_cr && bus.busy) begin
            if (sb.size() == 0) begin
                check("unexpected program end", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("event kind (prog)", 32'(e.kind == EV_PROG), 32'd1);
                check("prog pmux",         32'(bus.pmux),          32'(e.pmux));
                check("prog cycle_count",  32'(bus.cycle_count),   32'(e.cyc));
                check("prog prog_fail",    32'(bus.prog_fail),     32'(e.fail));
                check("prog timeout_err",  32'(bus.timeout_err),   32'(e.terr));
            end
        end
        if (!bus.busy && prev_busy && bus.all_done) begin
            if (sb.size() == 0) begin
                check("unexpected batch end", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("event kind (finish)", 32'(e.kind == EV_FINISH), 32'd1);
                check("finish pmux",         32'(bus.pmux),            32'(e.pmux));
                check("finish prog_fail",    32'(bus.prog_fail),       32'(e.fail));
                check("finish timeout_err",  32'(bus.timeout_err),     32'(e.terr));
            end
        end
        prev_cr   = bus.core_reset;
        prev_busy = bus.busy;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_prog(input int p, input int cyc, input logic [NP-1:0] fail, input logic terr);
        exp_t e;
        e.kind = EV_PROG;
        e.pmux = 2'(p);
        e.cyc  = 16'(cyc);
        e.fail = fail;
        e.terr = terr;
        sb.push_back(e);
    endtask

    task automatic push_finish(input logic [NP-1:0] fail, input logic terr);
        exp_t e;
        e.kind = EV_FINISH;
        e.pmux = 2'(NP - 1);
        e.cyc  = '0;
        e.fail = fail;
        e.terr = terr;
        sb.push_back(e);
    endtask

    task automatic set_core(input int m0, input int t0, input int m1, input int t1,
                            input int m2, input int t2);
        mode[0] = m0; tgt[0] = t0;
        mode[1] = m1; tgt[1] = t1;
        mode[2] = m2; tgt[2] = t2;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (!bus.busy) break;
            tick();
        end
        check({name, " finished in budget"}, 32'(bus.busy), 32'd0);
        tick(2);
    endtask

    task automatic wait_for(input int p, input int k, input string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (bus.pmux == 2'(p) && c == k) break;
            tick();
        end
        check({name, " reached"}, 32'(bus.pmux == 2'(p) && c == k), 32'd1);
    endtask

    task automatic check_reset_values(input string name);
        check({name, " core_reset"},  32'(bus.core_reset),  32'd1);
        check({name, " pmux"},        32'(bus.pmux),        32'd0);
        check({name, " busy"},        32'(bus.busy),        32'd0);
        check({name, " all_done"},    32'(bus.all_done),    32'd0);
        check({name, " timeout_err"}, 32'(bus.timeout_err), 32'd0);
        check({name, " prog_fail"},   32'(bus.prog_fail),   32'd0);
        check({name, " cycle_count"}, 32'(bus.cycle_count), 32'd0);
    endtask

    localparam logic [NP-1:0] F0 = '0;

    initial begin
        bus.start = 1'b0;
        set_core(0, 10, 0, 10, 0, 10);

        // Reset state
        reset = 1'b0;
        tick(3);
        check_reset_values("reset");
        reset = 1'b1;
        tick(2);

        // Normal batch: done after 10/20/30 RUN cycles, plus reset release timing
        set_core(0, 10, 0, 20, 0, 30);
        push_prog(0, 10, F0, 1'b0);
        push_prog(1, 20, F0, 1'b0);
        push_prog(2, 30, F0, 1'b0);
        push_finish(F0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy after start",          32'(bus.busy),       32'd1);
        check("core_reset after T0",       32'(bus.core_reset), 32'd1);
        tick();
        check("core_reset after T0+1",     32'(bus.core_reset), 32'd1);
        tick();
        check("core_reset after T0+2",     32'(bus.core_reset), 32'd0);
        wait_idle("normal");
        check("normal all_done",           32'(bus.all_done),    32'd1);
        check("normal timeout_err",        32'(bus.timeout_err), 32'd0);

        // Start pulsed during DRAIN of program 0 is ignored
        set_core(0, 6, 0, 6, 0, 6);
        push_prog(0, 6, F0, 1'b0);
        push_prog(1, 6, F0, 1'b0);
        push_prog(2, 6, F0, 1'b0);
        push_finish(F0, 1'b0);
        pulse_start();
        wait_for(0, 7, "drain of program 0");
        pulse_start();
        wait_idle("start-while-busy");
        check("busy batch all_done",       32'(bus.all_done), 32'd1);

        // Relaunch after FINISH clears all_done
        set_core(0, 4, 0, 4, 0, 4);
        push_prog(0, 4, F0, 1'b0);
        push_prog(1, 4, F0, 1'b0);
        push_prog(2, 4, F0, 1'b0);
        push_finish(F0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("relaunch all_done cleared", 32'(bus.all_done), 32'd0);
        check("relaunch busy",             32'(bus.busy),     32'd1);
        check("relaunch pmux",             32'(bus.pmux),     32'd0);
        wait_idle("relaunch");

        // Stale done on program 0; program 1 done exactly at the guard edge
        set_core(2, 0, 0, 2, 0, 12);
        push_prog(0, 8, F0, 1'b0);
        push_prog(1, 3, F0, 1'b0);
        push_prog(2, 12, F0, 1'b0);
        push_finish(F0, 1'b0);
        pulse_start();
        wait_idle("stale");

        // Done first high exactly at cnt == TIMEOUT-1: done wins
        set_core(0, TIMEOUT, 0, 5, 0, 7);
        push_prog(0, TIMEOUT, F0, 1'b0);
        push_prog(1, 5, F0, 1'b0);
        push_prog(2, 7, F0, 1'b0);
        push_finish(F0, 1'b0);
        pulse_start();
        wait_idle("simultaneous");

`ifdef PROG_SEQ_TIMEOUT_EN
        // Program 1 never finishes: timeout recorded, program 2 still runs
        set_core(0, 10, 1, 0, 0, 15);
        push_prog(0, 10, 3'b000, 1'b0);
        push_prog(1, TIMEOUT, 3'b010, 1'b1);
        push_prog(2, 15, 3'b010, 1'b1);
        push_finish(3'b010, 1'b1);
        pulse_start();
        wait_idle("timeout");
        check("timeout all_done",    32'(bus.all_done),    32'd1);
        check("timeout timeout_err", 32'(bus.timeout_err), 32'd1);
`endif

        // Reset mid-RUN of program 1, cycle 40
        set_core(0, 100, 0, 100, 0, 100);
        push_prog(0, 100, F0, 1'b0);
        pulse_start();
        wait_for(1, 40, "program 1 cycle 40");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_values("mid-run reset");
        tick(3);
        check("idle after abort busy", 32'(bus.busy), 32'd0);

        // Restart after abort begins at program 0
        set_core(0, 3, 0, 3, 0, 3);
        push_prog(0, 3, F0, 1'b0);
        push_prog(1, 3, F0, 1'b0);
        push_prog(2, 3, F0, 1'b0);
        push_finish(F0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart pmux", 32'(bus.pmux), 32'd0);
        check("restart busy", 32'(bus.busy), 32'd1);
        wait_idle("restart");

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
